mem_arbiter: RTL

// - Shares the single RAM port between the instruction fetch side (iREN) and
//   the data side (dREN/dWEN) driven by request_unit.
// - Sequences each RAM transaction and returns one-cycle ihit/dhit pulses that

---
 rtl/mem_arbiter_pkg.sv | 29 ++
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/arb_starve_counter.sv | 37 +++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared types for the RAM arbiter slice.
//   ramstate_t  : status reported by the RAM port (FREE, BUSY, ACCESS, ERROR)
//   word_t      : 32-bit machine word
//   arb_state_t : arbiter FSM states (IDLE, IACC, DACC)
//   is_data_req : helper that folds the data-side read/write enables into one request

package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        IACC = 2'b01,
        DACC = 2'b10
    } arb_state_t;

    function automatic logic is_data_req(input logic ren, input logic wen);
        return ren | wen;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the instruction request, data request and RAM port signals that
//   meet at the arbiter.
//   slave  modport : arbiter view (requests and RAM status in, hits/loads and
//                    RAM command out)
//   master modport : requester/RAM-model view (the mirror image)
//   Instruction side : iREN, iaddr -> iload, ihit
//   Data side        : dREN, dWEN, daddr, dstore -> dload, dhit
//   RAM side         : ramREN, ramWEN, ramaddr, ramstore <- ramload, ramstate

interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import mem_arbiter_pkg::*;

    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic [DATA_W-1:0] iload;
    logic              ihit;

    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic [DATA_W-1:0] dload;
    logic              dhit;

    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    ramstate_t         ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/arb_starve_counter.sv
// arb_starve_counter
//   Counts consecutive data grants completed while an instruction fetch was
//   waiting. Saturates at STARVE_MAX; sat tells the arbiter to give the next
//   grant to instruction fetch.
//   clk   in  clock, rising edge
//   rst_n in  asynchronous active-low reset
//   inc   in  data completion with instruction fetch pending
//   clr   in  instruction completion, or data completion with no fetch pending
//   sat   out count has reached STARVE_MAX

module arb_starve_counter #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign sat = (count == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single RAM port between instruction fetch and the data side.
//   Data requests win arbitration unless instruction fetch has been passed
//   over STARVE_MAX times in a row. Each transaction holds the RAM command
//   until the RAM reports ACCESS, then pulses ihit or dhit for one cycle and
//   returns to IDLE for one cycle before re-arbitrating.
//   CLK   in  clock, rising edge
//   nRST  in  asynchronous active-low reset
//   bus   slave modport of mem_arbiter_if (requests, hits, loads, RAM port)

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic         CLK,
    input  logic         nRST,
    mem_arbiter_if.slave bus
);

    arb_state_t        state;
    arb_state_t        next_state;
    logic              d_req;
    logic              starve_inc;
    logic              starve_clr;
    logic              starve_sat;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] store_sel;

    assign d_req = is_data_req(bus.dREN, bus.dWEN);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Outputs are decoded from the state, so the asynchronous reset forcing
    // IDLE also drops every output within the same cycle.
    always_comb begin
        next_state   = state;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ihit     = 1'b0;
        bus.dhit     = 1'b0;
        addr_sel     = '0;
        store_sel    = '0;
        starve_inc   = 1'b0;
        starve_clr   = 1'b0;

        case (state)
            IDLE: begin
                if (d_req && !(starve_sat && bus.iREN)) begin
                    next_state = DACC;
                end else if (bus.iREN) begin
                    next_state = IACC;
                end
            end

            IACC: begin
                if (!bus.iREN) begin
                    // Withdrawn before completion: abort, counter untouched.
                    next_state = IDLE;
                end else begin
                    bus.ramREN = 1'b1;
                    addr_sel   = bus.iaddr;
                    bus.iload  = bus.ramload;
                    if (bus.ramstate == ACCESS) begin
                        bus.ihit   = 1'b1;
                        starve_clr = 1'b1;
                        next_state = IDLE;
                    end
                end
            end

            DACC: begin
                if (!d_req) begin
                    next_state = IDLE;
                end else begin
                    // A simultaneous read and write request is served as a write.
                    bus.ramWEN = bus.dWEN;
                    bus.ramREN = !bus.dWEN;
                    addr_sel   = bus.daddr;
                    store_sel  = bus.dstore;
                    bus.dload  = bus.ramload;
                    if (bus.ramstate == ACCESS) begin
                        bus.dhit   = 1'b1;
                        starve_inc = bus.iREN;
                        starve_clr = !bus.iREN;
                        next_state = IDLE;
                    end
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign bus.ramaddr  = addr_sel;
    assign bus.ramstore = store_sel;

    arb_starve_counter #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk   (CLK),
        .rst_n (nRST),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .sat   (starve_sat)
    );

endmodule
